// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard/stall controller.
//   Defines : ADDR_WIDTH, RADDR_WIDTH, MEM_NOP, state encodings, stage bit
//             indices and trap cause codes (macros, visible to later files).
//   Package : state_t enum built on the state encoding macros.
`ifndef PIPE_CTRL_DEFINES_SV
`define PIPE_CTRL_DEFINES_SV
`define ADDR_WIDTH        32
`define RADDR_WIDTH       5
`define MEM_NOP           4'h0
`define ST_RUN            2'd0
`define ST_MEM_WAIT       2'd1
`define ST_BUS_ERR        2'd2
`define STG_PC            0
`define STG_IFID          1
`define STG_IDEX          2
`define STG_EXMEM         3
`define STG_MEMWB         4
`define CAUSE_LOAD_FAULT  4'd5
`define CAUSE_STORE_FAULT 4'd7
`define CAUSE_ECALL       4'd11
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = `ST_RUN,
    MEM_WAIT = `ST_MEM_WAIT,
    BUS_ERR  = `ST_BUS_ERR
  } state_t;

  localparam int NUM_STAGES = 5;

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// load_use_det: combinational load-use hazard detector.
//   Inputs : ex_is_load_i, ex_rd_i (load in ID/EX and its destination),
//            id_rs1_i/id_rs2_i with read enables (sources in ID).
//   Output : hazard_o, high when the ID instruction reads the load's rd.
//   x0 is never a hazard since it is hard-wired to zero.
module load_use_det (
  input  logic                    ex_is_load_i,
  input  logic [`RADDR_WIDTH-1:0] ex_rd_i,
  input  logic [`RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [`RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                    id_rs1_re_i,
  input  logic                    id_rs2_re_i,
  output logic                    hazard_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_rs1_re_i && (id_rs1_i == ex_rd_i);
  assign w_rs2_hit = id_rs2_re_i && (id_rs2_i == ex_rd_i);
  assign hazard_o  = ex_is_load_i && (ex_rd_i != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect/trap controller.
//   Inputs : clk_i, rst_i (async, active-high), EX/MEM memory op + ack,
//            load-use operands, resolved branch, ecall/PC/mtvec.
//   Outputs: stall_o/flush_o (bit 0 PC .. bit 4 MEM/WB), mem_req_o,
//            redirect_o/redirect_pc_o, trap_o/trap_cause_o/trap_epc_o.
//   Option : define PIPE_CTRL_TIMEOUT_EN to add the MEM_WAIT timeout counter
//            and the one-cycle BUS_ERR trap state.
//
//   state    | meaning
//   RUN      | normal flow; a memory op without ack stalls and enters MEM_WAIT
//   MEM_WAIT | data bus busy; stall until ack
//   BUS_ERR  | one cycle: flush everything, raise access-fault trap
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [3:0]              ex_mem_op_i,
  input  logic                    ex_mem_we_i,
  input  logic                    mem_ack_i,
  input  logic                    ex_is_load_i,
  input  logic [`RADDR_WIDTH-1:0] ex_rd_i,
  input  logic [`RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [`RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                    id_rs1_re_i,
  input  logic                    id_rs2_re_i,
  input  logic                    branch_taken_i,
  input  logic [`ADDR_WIDTH-1:0]  branch_target_i,
  input  logic                    ecall_i,
  input  logic [`ADDR_WIDTH-1:0]  ex_pc_i,
  input  logic [`ADDR_WIDTH-1:0]  mtvec_i,
  output logic [4:0]              stall_o,
  output logic [4:0]              flush_o,
  output logic                    mem_req_o,
  output logic                    redirect_o,
  output logic [`ADDR_WIDTH-1:0]  redirect_pc_o,
  output logic                    trap_o,
  output logic [3:0]              trap_cause_o,
  output logic [`ADDR_WIDTH-1:0]  trap_epc_o
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load_use;
  logic   w_mem_stall;
  logic   w_bus_err;
  logic   w_timeout;

  load_use_det u_load_use_det (
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_re_i  (id_rs1_re_i),
    .id_rs2_re_i  (id_rs2_re_i),
    .hazard_o     (w_load_use)
  );

`ifdef PIPE_CTRL_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Counts completed MEM_WAIT cycles; any other state clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_wait_cnt <= '0;
    else if (r_state == MEM_WAIT && !mem_ack_i)
      r_wait_cnt <= r_wait_cnt + 8'd1;
    else
      r_wait_cnt <= '0;
  end

  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ex_mem_we_i ^ (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_stall   = 1'b0;
    w_bus_err     = 1'b0;
    stall_o       = '0;
    flush_o       = '0;
    mem_req_o     = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    trap_o        = 1'b0;
    trap_cause_o  = '0;
    trap_epc_o    = '0;

    case (r_state)
      RUN: begin
        mem_req_o = (ex_mem_op_i != `MEM_NOP);
        if (mem_req_o && !mem_ack_i) begin
          w_mem_stall = 1'b1;
          w_state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          w_state_nxt = RUN;
        end else begin
          w_mem_stall = 1'b1;
          if (w_timeout) w_state_nxt = BUS_ERR;
        end
      end
      BUS_ERR: begin
        w_bus_err   = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase

    // Priority chain: lower events are dropped, the stalled stages re-present them.
    if (w_bus_err) begin
      flush_o       = '1;
      trap_o        = 1'b1;
      trap_cause_o  = ex_mem_we_i ? `CAUSE_STORE_FAULT : `CAUSE_LOAD_FAULT;
      trap_epc_o    = ex_pc_i;
      redirect_o    = 1'b1;
      redirect_pc_o = mtvec_i;
    end else if (w_mem_stall) begin
      stall_o[`STG_EXMEM:`STG_PC] = '1;
      flush_o[`STG_MEMWB]         = 1'b1;
    end else if (ecall_i) begin
      trap_o                       = 1'b1;
      trap_cause_o                 = `CAUSE_ECALL;
      trap_epc_o                   = ex_pc_i;
      redirect_o                   = 1'b1;
      redirect_pc_o                = mtvec_i;
      flush_o[`STG_EXMEM:`STG_IFID] = '1;
    end else if (branch_taken_i) begin
      redirect_o                   = 1'b1;
      redirect_pc_o                = branch_target_i;
      flush_o[`STG_IDEX:`STG_IFID] = '1;
    end else if (w_load_use) begin
      stall_o[`STG_IFID:`STG_PC] = '1;
      flush_o[`STG_IDEX]         = 1'b1;
    end

    // Reset silences every output immediately, even mid-transaction.
    if (rst_i) begin
      stall_o       = '0;
      flush_o       = '0;
      mem_req_o     = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      trap_o        = 1'b0;
      trap_cause_o  = '0;
      trap_epc_o    = '0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  ex_mem_op_i;
  logic        ex_mem_we_i;
  logic        mem_ack_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        ecall_i;
  logic [31:0] ex_pc_i;
  logic [31:0] mtvec_i;
  logic [4:0]  stall_o;
  logic [4:0]  flush_o;
  logic        mem_req_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        trap_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_epc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ex_mem_op_i     (ex_mem_op_i),
    .ex_mem_we_i     (ex_mem_we_i),
    .mem_ack_i       (mem_ack_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_rd_i         (ex_rd_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_rs1_re_i     (id_rs1_re_i),
    .id_rs2_re_i     (id_rs2_re_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .ecall_i         (ecall_i),
    .ex_pc_i         (ex_pc_i),
    .mtvec_i         (mtvec_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .mem_req_o       (mem_req_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .trap_o          (trap_o),
    .trap_cause_o    (trap_cause_o),
    .trap_epc_o      (trap_epc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_mem_op_i = 4'h0; ex_mem_we_i = 1'b0; mem_ack_i = 1'b0;
    ex_is_load_i = 1'b0; ex_rd_i = '0; id_rs1_i = '0; id_rs2_i = '0;
    id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = 32'h200; ecall_i = 1'b0;
    ex_pc_i = 32'h40; mtvec_i = 32'h100;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    ex_mem_op_i = 4'h1; ecall_i = 1'b1; branch_taken_i = 1'b1;
    #1;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_trap", 32'(trap_o), 32'h0);
    chk("rst_redirect_pc", redirect_pc_o, 32'h0);
    step(); step();
    idle(); rst_i = 1'b0;

    // Stray ack with nothing pending
    mem_ack_i = 1'b1; #1;
    chk("stray_ack_req", 32'(mem_req_o), 32'h0);
    chk("stray_ack_stall", 32'(stall_o), 32'h0);

    // Load acked the same cycle
    step(); idle(); ex_mem_op_i = 4'h1; mem_ack_i = 1'b1; #1;
    chk("load_ack_req", 32'(mem_req_o), 32'h1);
    chk("load_ack_stall", 32'(stall_o), 32'h0);
    chk("load_ack_flush", 32'(flush_o), 32'h0);
    step(); idle(); #1;
    chk("load_done_req", 32'(mem_req_o), 32'h0);

    // Store acked on the fourth cycle; ecall/branch suppressed while stalled
    step(); ex_mem_op_i = 4'h2; ex_mem_we_i = 1'b1; ecall_i = 1'b1; branch_taken_i = 1'b1; #1;
    chk("st_w0_stall", 32'(stall_o), 32'h0F);
    chk("st_w0_flush", 32'(flush_o), 32'h10);
    chk("st_w0_trap", 32'(trap_o), 32'h0);
    chk("st_w0_redirect", 32'(redirect_o), 32'h0);
    for (int i = 1; i < 3; i++) begin
      step(); #1;
      chk($sformatf("st_w%0d_stall", i), 32'(stall_o), 32'h0F);
      chk($sformatf("st_w%0d_req", i), 32'(mem_req_o), 32'h1);
    end
    step(); ecall_i = 1'b0; mem_ack_i = 1'b1; #1;
    chk("st_ack_stall", 32'(stall_o), 32'h0);
    chk("st_ack_req", 32'(mem_req_o), 32'h1);
    chk("st_ack_branch", 32'(redirect_pc_o), 32'h200);
    step(); idle(); #1;
    chk("st_back_run_req", 32'(mem_req_o), 32'h0);
    chk("st_back_run_stall", 32'(stall_o), 32'h0);

    // Load-use hazards
    step(); ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_re_i = 1'b1; #1;
    chk("lu_rs2_stall", 32'(stall_o), 32'h03);
    chk("lu_rs2_flush", 32'(flush_o), 32'h04);
    step(); ex_rd_i = 5'd0; id_rs2_i = 5'd0; #1;
    chk("lu_x0_stall", 32'(stall_o), 32'h0);
    step(); idle(); ex_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; #1;
    chk("lu_rs1_noren", 32'(stall_o), 32'h0);
    id_rs1_re_i = 1'b1; #1;
    chk("lu_rs1_stall", 32'(stall_o), 32'h03);
    ex_is_load_i = 1'b0; #1;
    chk("lu_notload", 32'(stall_o), 32'h0);

    // Ecall beats branch; branch beats load-use
    step(); idle(); branch_taken_i = 1'b1; ecall_i = 1'b1; #1;
    chk("ec_br_redirect_pc", redirect_pc_o, 32'h100);
    chk("ec_br_cause", 32'(trap_cause_o), 32'd11);
    chk("ec_br_epc", trap_epc_o, 32'h40);
    chk("ec_br_flush", 32'(flush_o), 32'h0E);
    step(); ecall_i = 1'b0; ex_is_load_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; id_rs1_re_i = 1'b1; #1;
    chk("br_pc", redirect_pc_o, 32'h200);
    chk("br_flush", 32'(flush_o), 32'h06);
    chk("br_stall", 32'(stall_o), 32'h0);
    chk("br_cause_zero", 32'(trap_cause_o), 32'h0);
    chk("br_epc_zero", trap_epc_o, 32'h0);

    // Reset in the middle of MEM_WAIT
    step(); idle(); ex_mem_op_i = 4'h1; #1;
    step(); #1;
    chk("rw_wait_req", 32'(mem_req_o), 32'h1);
    rst_i = 1'b1; #1;
    chk("rw_rst_req", 32'(mem_req_o), 32'h0);
    chk("rw_rst_stall", 32'(stall_o), 32'h0);
    chk("rw_rst_flush", 32'(flush_o), 32'h0);
    step(); rst_i = 1'b0; idle(); #1;
    chk("rw_run_req", 32'(mem_req_o), 32'h0);

    // Unacked store: timeout trap when enabled, indefinite wait otherwise
    step(); ex_mem_op_i = 4'h2; ex_mem_we_i = 1'b1; ex_pc_i = 32'h88; #1;
    chk("to_first_stall", 32'(stall_o), 32'h0F);
`ifdef PIPE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk($sformatf("to_wait%0d_stall", i), 32'(stall_o), 32'h0F);
    end
    step(); #1;
    chk("to_berr_flush", 32'(flush_o), 32'h1F);
    chk("to_berr_trap", 32'(trap_o), 32'h1);
    chk("to_berr_cause", 32'(trap_cause_o), 32'd7);
    chk("to_berr_epc", trap_epc_o, 32'h88);
    chk("to_berr_pc", redirect_pc_o, 32'h100);
    chk("to_berr_req", 32'(mem_req_o), 32'h0);
    chk("to_berr_stall", 32'(stall_o), 32'h0);
    step(); mem_ack_i = 1'b1; #1;
    chk("to_run_req", 32'(mem_req_o), 32'h1);
    chk("to_run_trap", 32'(trap_o), 32'h0);
`else
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk($sformatf("nt_wait%0d_stall", i), 32'(stall_o), 32'h0F);
      chk($sformatf("nt_wait%0d_trap", i), 32'(trap_o), 32'h0);
    end
    step(); mem_ack_i = 1'b1; #1;
    chk("nt_ack_stall", 32'(stall_o), 32'h0);
    step(); idle(); #1;
    chk("nt_run_req", 32'(mem_req_o), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
